// File: rtl/signmag_accum_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | signmag_accum_if : sample/dump bus between correlator and accumulator |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface signmag_accum_if #(
  parameter int ACC_W = 20,
  parameter int CNT_W = 16
);
  logic             en;
  logic [4:0]       din_i;
  logic [4:0]       din_q;
  logic             dump;
  logic [ACC_W-1:0] acc_i;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             dump_valid;

  modport master (
    output en, din_i, din_q, dump,
    input  acc_i, acc_q, cnt, ovf, dump_valid
  );

  modport slave (
    input  en, din_i, din_q, dump,
    output acc_i, acc_q, cnt, ovf, dump_valid
  );
endinterface
`default_nettype wire

// File: rtl/signmag_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | signmag_accum : I/Q integrate-and-dump of sign-magnitude products     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module signmag_accum #(
  parameter int ACC_W = 20,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            clr,
  signmag_accum_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_ALIGN = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Symmetric rails: the most-negative code is never produced.
  localparam logic signed [ACC_W:0] c_pos_max = $signed({2'b00, {(ACC_W-1){1'b1}}});
  localparam logic signed [ACC_W:0] c_neg_max = -c_pos_max;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] sum_i_q, sum_i_d;
  logic [ACC_W-1:0] sum_q_q, sum_q_d;
  logic [CNT_W-1:0] cnt_int_q, cnt_int_d;
  logic             sticky_q, sticky_d;
  logic [ACC_W-1:0] acc_i_q, acc_i_d;
  logic [ACC_W-1:0] acc_q_q, acc_q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             dump_valid_q, dump_valid_d;

  logic [ACC_W:0]   add_i, add_q;
  logic [ACC_W-1:0] epoch_i, epoch_q;
  logic [CNT_W-1:0] epoch_cnt;
  logic             epoch_ovf;

  function automatic logic [ACC_W-1:0] to_tc(input logic [4:0] sm);
    logic [ACC_W-1:0] mag;
    mag = {{(ACC_W-4){1'b0}}, sm[3:0]};
    return sm[4] ? -mag : mag;
  endfunction

  // Returns {clamped, saturated sum}.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = $signed({a[ACC_W-1], a}) + $signed({b[ACC_W-1], b});
    if (s > c_pos_max) return {1'b1, c_pos_max[ACC_W-1:0]};
    if (s < c_neg_max) return {1'b1, c_neg_max[ACC_W-1:0]};
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  // Epoch values including this cycle's sample, if any.
  always_comb begin
    add_i     = sat_add(sum_i_q, to_tc(bus.din_i));
    add_q     = sat_add(sum_q_q, to_tc(bus.din_q));
    epoch_i   = sum_i_q;
    epoch_q   = sum_q_q;
    epoch_cnt = cnt_int_q;
    epoch_ovf = sticky_q;
    if (bus.en) begin
      epoch_i   = add_i[ACC_W-1:0];
      epoch_q   = add_q[ACC_W-1:0];
      epoch_cnt = (cnt_int_q == '1) ? cnt_int_q : cnt_int_q + 1'b1;
      epoch_ovf = sticky_q | add_i[ACC_W] | add_q[ACC_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    sum_i_d      = sum_i_q;
    sum_q_d      = sum_q_q;
    cnt_int_d    = cnt_int_q;
    sticky_d     = sticky_q;
    acc_i_d      = acc_i_q;
    acc_q_d      = acc_q_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    dump_valid_d = 1'b0;
    case (state_q)
      ST_ALIGN: begin
        if (bus.dump) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.dump) begin
          acc_i_d      = epoch_i;
          acc_q_d      = epoch_q;
          cnt_d        = epoch_cnt;
          ovf_d        = epoch_ovf;
          dump_valid_d = 1'b1;
          sum_i_d      = '0;
          sum_q_d      = '0;
          cnt_int_d    = '0;
          sticky_d     = 1'b0;
        end else begin
          sum_i_d   = epoch_i;
          sum_q_d   = epoch_q;
          cnt_int_d = epoch_cnt;
          sticky_d  = epoch_ovf;
        end
      end
      default: state_d = ST_ALIGN;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= ST_ALIGN;
      sum_i_q      <= '0;
      sum_q_q      <= '0;
      cnt_int_q    <= '0;
      sticky_q     <= 1'b0;
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      dump_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_i_q      <= sum_i_d;
      sum_q_q      <= sum_q_d;
      cnt_int_q    <= cnt_int_d;
      sticky_q     <= sticky_d;
      acc_i_q      <= acc_i_d;
      acc_q_q      <= acc_q_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      dump_valid_q <= dump_valid_d;
    end
  end

  assign bus.acc_i      = acc_i_q;
  assign bus.acc_q      = acc_q_q;
  assign bus.cnt        = cnt_q;
  assign bus.ovf        = ovf_q;
  assign bus.dump_valid = dump_valid_q;

endmodule
`default_nettype wire
